// File: rtl/comma_sync.sv
// comma_sync: comma-based word lock FSM (HUNT/CHECK/LOCKED) with registered data pass-through.
module comma_sync #(
  parameter int BYTES    = 4,
  parameter int GOOD_CNT = 4,
  parameter int BAD_CNT  = 3,
  parameter int TIMEOUT  = 16
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [BYTES-1:0]   pattern_i,
  input  logic [BYTES-1:0]   comma_i,
  input  logic [BYTES*8-1:0] data_i,
  input  logic               err_i,
  output logic               hold_o,
  output logic               locked_o,
  output logic               loss_o,
  output logic [1:0]         state_o,
  output logic               valid_o,
  output logic [BYTES-1:0]   comma_o,
  output logic [BYTES*8-1:0] data_o
);
  localparam int GW = $clog2(256);
  localparam int BW = $clog2(256);
  localparam int TW = $clog2(65536);
  typedef enum logic [1:0] {HUNT = 2'b00, CHECK = 2'b01, LOCKED = 2'b10} st_t;
  st_t state;
  logic [GW-1:0] gcnt, ginc;
  logic [BW-1:0] bcnt, binc;
  logic [TW-1:0] tcnt, tnxt;
  logic good, tmo, bad;
  always_comb begin
    good = (comma_i == pattern_i) && !err_i;
    tmo  = (state != HUNT) && (tcnt == TW'(TIMEOUT - 1)) && !good;
    bad  = err_i || ((comma_i != '0) && (comma_i != pattern_i)) || tmo;
    ginc = (gcnt == '1) ? gcnt : gcnt + 1'b1;
    binc = (bcnt == '1) ? bcnt : bcnt + 1'b1;
    tnxt = (good || tmo) ? '0 : (tcnt == '1) ? tcnt : tcnt + 1'b1;
  end
  assign state_o = state;
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state    <= HUNT;
      gcnt     <= '0;
      bcnt     <= '0;
      tcnt     <= '0;
      hold_o   <= 1'b0;
      locked_o <= 1'b0;
      loss_o   <= 1'b0;
      valid_o  <= 1'b0;
      comma_o  <= '0;
      data_o   <= '0;
    end else begin
      data_o  <= data_i;
      comma_o <= comma_i;
      valid_o <= (state == LOCKED) && !err_i;
      loss_o  <= 1'b0;
      case (state)
        HUNT: begin
          tcnt <= '0;
          bcnt <= '0;
          gcnt <= '0;
          if (good && GOOD_CNT == 1) begin
            state    <= LOCKED;
            hold_o   <= 1'b1;
            locked_o <= 1'b1;
          end else if (good) begin
            state  <= CHECK;
            gcnt   <= GW'(1);
            hold_o <= 1'b1;
          end
        end
        CHECK: begin
          tcnt <= tnxt;
          if (bad) begin
            state  <= HUNT;
            gcnt   <= '0;
            tcnt   <= '0;
            hold_o <= 1'b0;
          end else if (good && ginc >= GW'(GOOD_CNT)) begin
            state    <= LOCKED;
            gcnt     <= '0;
            bcnt     <= '0;
            locked_o <= 1'b1;
          end else if (good)
            gcnt <= ginc;
        end
        LOCKED: begin
          tcnt <= tnxt;
          if (bad && binc >= BW'(BAD_CNT)) begin
            state    <= HUNT;
            gcnt     <= '0;
            bcnt     <= '0;
            tcnt     <= '0;
            hold_o   <= 1'b0;
            locked_o <= 1'b0;
            loss_o   <= 1'b1;
          end else if (bad)
            bcnt <= binc;
          else if (good)
            bcnt <= '0;
        end
        default: begin
          state    <= HUNT;
          gcnt     <= '0;
          bcnt     <= '0;
          tcnt     <= '0;
          hold_o   <= 1'b0;
          locked_o <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_comma_sync.sv
// tb_comma_sync: table-driven directed check of comma_sync lock/loss/timeout behaviour.
module tb_comma_sync;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  pattern = 4'b0001;
  logic [3:0]  comma = '0;
  logic [31:0] data = '0;
  logic        err = 1'b0;
  logic        hold, locked, loss, valid;
  logic [1:0]  state;
  logic [3:0]  comma_q;
  logic [31:0] data_q;
  int tests = 0;
  int fails = 0;

  comma_sync #(.BYTES(4), .GOOD_CNT(4), .BAD_CNT(3), .TIMEOUT(16)) dut (
    .clk_i(clk), .rst_i(rst), .pattern_i(pattern), .comma_i(comma), .data_i(data),
    .err_i(err), .hold_o(hold), .locked_o(locked), .loss_o(loss), .state_o(state),
    .valid_o(valid), .comma_o(comma_q), .data_o(data_q)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       r;
    logic [3:0] c;
    logic       e;
    int         n;
    logic       all;
    logic [1:0] s;
    logic       l, ls, h, v;
  } vec_t;

  vec_t tv[$];

  task automatic add(input logic r, input logic [3:0] c, input logic e, input int n,
                     input logic all, input logic [1:0] s, input logic l, input logic ls,
                     input logic h, input logic v);
    vec_t x;
    x.r = r; x.c = c; x.e = e; x.n = n; x.all = all;
    x.s = s; x.l = l; x.ls = ls; x.h = h; x.v = v;
    tv.push_back(x);
  endtask

  task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s vec %0d: got %0h expected %0h", nm, idx, act, exp);
    end
  endtask

  task automatic apply(input logic r, input logic [3:0] c, input logic e, input int idx);
    logic [31:0] d;
    d = $urandom;
    @(negedge clk);
    rst = r; comma = c; err = e; data = d;
    @(posedge clk);
    #1;
    chk("data_o", idx, data_q, r ? 32'h0 : d);
    chk("comma_o", idx, {28'h0, comma_q}, r ? 32'h0 : {28'h0, c});
  endtask

  task automatic outs(input int idx, input logic [1:0] s, input logic l, input logic ls,
                      input logic h, input logic v);
    chk("state_o", idx, {30'h0, state}, {30'h0, s});
    chk("locked_o", idx, {31'h0, locked}, {31'h0, l});
    chk("loss_o", idx, {31'h0, loss}, {31'h0, ls});
    chk("hold_o", idx, {31'h0, hold}, {31'h0, h});
    chk("valid_o", idx, {31'h0, valid}, {31'h0, v});
  endtask

  initial begin
    // r c e n all | state locked loss hold valid (checked after the last step, or every step)
    add(1, 4'h0, 0, 2, 1, 2'b00, 0, 0, 0, 0);
    add(0, 4'h1, 0, 1, 0, 2'b01, 0, 0, 1, 0);
    add(0, 4'h0, 0, 7, 1, 2'b01, 0, 0, 1, 0);
    add(0, 4'h1, 0, 1, 0, 2'b01, 0, 0, 1, 0);
    add(0, 4'h0, 0, 7, 1, 2'b01, 0, 0, 1, 0);
    add(0, 4'h1, 0, 1, 0, 2'b01, 0, 0, 1, 0);
    add(0, 4'h0, 0, 7, 1, 2'b01, 0, 0, 1, 0);
    add(0, 4'h1, 0, 1, 0, 2'b10, 1, 0, 1, 0);
    add(0, 4'h0, 0, 1, 0, 2'b10, 1, 0, 1, 1);
    add(0, 4'h0, 1, 2, 1, 2'b10, 1, 0, 1, 0);
    add(0, 4'h1, 0, 1, 0, 2'b10, 1, 0, 1, 1);
    add(0, 4'h0, 1, 2, 1, 2'b10, 1, 0, 1, 0);
    add(0, 4'h0, 1, 1, 0, 2'b00, 0, 1, 0, 0);
    add(0, 4'h0, 0, 1, 0, 2'b00, 0, 0, 0, 0);
    add(0, 4'h4, 0, 1, 0, 2'b00, 0, 0, 0, 0);
    add(0, 4'h1, 1, 1, 0, 2'b00, 0, 0, 0, 0);
    add(0, 4'h0, 0, 20, 1, 2'b00, 0, 0, 0, 0);
    add(0, 4'h1, 0, 4, 0, 2'b10, 1, 0, 1, 0);
    add(1, 4'h1, 0, 1, 0, 2'b00, 0, 0, 0, 0);
    add(0, 4'h1, 0, 2, 0, 2'b01, 0, 0, 1, 0);
    add(0, 4'h4, 0, 1, 0, 2'b00, 0, 0, 0, 0);
    add(0, 4'h1, 0, 4, 0, 2'b10, 1, 0, 1, 0);
    add(0, 4'h0, 0, 15, 1, 2'b10, 1, 0, 1, 1);
    add(0, 4'h0, 0, 1, 0, 2'b10, 1, 0, 1, 1);
    add(0, 4'h0, 0, 15, 1, 2'b10, 1, 0, 1, 1);
    add(0, 4'h0, 0, 1, 0, 2'b10, 1, 0, 1, 1);
    add(0, 4'h0, 0, 15, 1, 2'b10, 1, 0, 1, 1);
    add(0, 4'h0, 0, 1, 0, 2'b00, 0, 1, 0, 1);
    add(0, 4'h0, 0, 1, 0, 2'b00, 0, 0, 0, 0);
    add(0, 4'h1, 0, 1, 0, 2'b01, 0, 0, 1, 0);
    add(0, 4'h0, 0, 15, 1, 2'b01, 0, 0, 1, 0);
    add(0, 4'h0, 0, 1, 0, 2'b00, 0, 0, 0, 0);

    for (int i = 0; i < tv.size(); i++)
      for (int k = 0; k < tv[i].n; k++) begin
        apply(tv[i].r, tv[i].c, tv[i].e, i);
        if (tv[i].all || k == tv[i].n - 1)
          outs(i, tv[i].s, tv[i].l, tv[i].ls, tv[i].h, tv[i].v);
      end

    // lock, then an err-flagged pattern word counts as bad; reset while LOCKED gives no loss pulse
    for (int k = 0; k < 4; k++) apply(0, 4'h1, 0, 100);
    outs(100, 2'b10, 1, 0, 1, 0);
    apply(0, 4'h1, 1, 101);
    apply(0, 4'h1, 1, 101);
    outs(101, 2'b10, 1, 0, 1, 0);
    apply(1, 4'h0, 0, 102);
    outs(102, 2'b00, 0, 0, 0, 0);
    apply(0, 4'h0, 0, 103);
    outs(103, 2'b00, 0, 0, 0, 0);
    apply(0, 4'h1, 0, 104);
    outs(104, 2'b01, 0, 0, 1, 0);
    // reset during CHECK also drops straight to HUNT silently
    apply(1, 4'h1, 0, 105);
    outs(105, 2'b00, 0, 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/comma_sync.md
COMMA_SYNC -- requirements
Module: comma_sync

Interface
REQ-001 SHALL have parameter BYTES, default 4, bytes per data word.
REQ-002 SHALL have parameter GOOD_CNT, default 4, consecutive good commas needed to lock (range 1..255).
REQ-003 SHALL have parameter BAD_CNT, default 3, bad events needed to drop lock (range 1..255).
REQ-004 SHALL have parameter TIMEOUT, default 16, max cycles between good commas (range 2..65535).
REQ-005 SHALL have clk_i  in  1  the only clock; all logic on its rising edge.
REQ-006 SHALL have rst_i  in  1  reset, synchronous and active-high.
REQ-007 SHALL have pattern_i  in  BYTES  expected per-byte comma flags of a correctly aligned comma word.
REQ-008 SHALL have comma_i  in  BYTES  per-byte comma flags from the boundary aligner output.
REQ-009 SHALL have data_i  in  BYTES*8  aligned data from the boundary aligner.
REQ-010 SHALL have err_i  in  1  code/disparity error for the current word.
REQ-011 SHALL have hold_o  out  1  freeze aligner byte index while high.
REQ-012 SHALL have locked_o  out  1  link synchronised.
REQ-013 SHALL have loss_o  out  1  one-cycle pulse on lock loss.
REQ-014 SHALL have state_o  out  2  current state encoding.
REQ-015 SHALL have valid_o  out  1  qualifies data_o/comma_o.
REQ-016 SHALL have comma_o  out  BYTES  registered comma_i.
REQ-017 SHALL have data_o  out  BYTES*8  registered data_i.

Function
REQ-018 SHALL classify each cycle: good = (comma_i == pattern_i) and !err_i; bad = err_i, or (comma_i != 0 and comma_i != pattern_i), or timeout; neutral = otherwise.
REQ-019 SHALL keep a timeout counter cleared on good, or on entering HUNT, and incremented otherwise; timeout = counter == TIMEOUT-1 with no good in that cycle; the counter then clears.
REQ-020 SHALL treat a word flagged both good-pattern and err_i as bad (error wins).
REQ-021 SHALL implement states HUNT=2'b00, CHECK=2'b01, LOCKED=2'b10; 2'b11 unused and SHALL recover to HUNT on the next cycle.
REQ-022 HUNT: hold_o=0, timeout counter held at 0, no timeout events; good -> CHECK with good count=1 (if GOOD_CNT==1, -> LOCKED directly); all else stay.
REQ-023 CHECK: hold_o=1; good increments good count, reaching GOOD_CNT -> LOCKED; any bad -> HUNT, good count cleared; neutral stays.
REQ-024 LOCKED: hold_o=1, locked_o=1; bad increments bad count, reaching BAD_CNT -> HUNT with loss_o=1 for exactly that one cycle; good clears bad count; neutral holds bad count.
REQ-025 SHALL clear both good and bad counts on every state entry.
REQ-026 SHALL register state-derived outputs (hold_o, locked_o, state_o) so they reflect the state after the transition clock edge; state-change latency 1 cycle from the deciding input.
REQ-027 SHALL register data_o/comma_o with 1-cycle latency every cycle regardless of state.
REQ-028 SHALL drive valid_o = 1 on the cycle data_o carries a word sampled while state was LOCKED and err_i was 0; else 0.
REQ-029 Counters SHALL saturate and never wrap; widths SHALL be the minimum ceil(log2) width that holds each parameter's range.

Reset
REQ-030 While rst_i=1 at a clock edge: state=HUNT, all counters 0, hold_o=0, locked_o=0, loss_o=0, valid_o=0, state_o=2'b00, comma_o=0, data_o=0.
REQ-031 Reset asserted mid-operation (any state) SHALL take effect at the next edge with no loss_o pulse generated.

Verification (BYTES=4, GOOD_CNT=4, BAD_CNT=3, TIMEOUT=16, pattern_i=4'b0001)
REQ-032 Acquire: comma_i=4'b0001 every 8 cycles, err_i=0 -> state_o 01 after 1st comma, 10 after 4th comma, locked_o=1, valid_o=1 one cycle later.
REQ-033 Misalign in CHECK: after 2 good commas, comma_i=4'b0100 -> state_o=00, hold_o=0 next cycle, no loss_o.
REQ-034 Loss of lock: locked, then 3 cycles err_i=1 (no intervening good) -> loss_o=1 for one cycle on 3rd, state_o=00, locked_o=0.
REQ-035 Bad-count clear: locked, 2 errors, 1 good comma, 2 errors -> remains LOCKED, loss_o never 1.
REQ-036 Timeout: locked, comma_i=0 for 48 cycles -> bad events at cycles 16, 32, 48; loss_o on 48th cycle.
REQ-037 Reset mid-lock: rst_i=1 one cycle while LOCKED -> all outputs 0, state_o=00, next good comma restarts CHECK.
